// File: rtl/fifo_burst_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and default sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // waiting for a burst request
        ST_WAIT   = 2'd1,  // request latched, waiting for enough FIFO fill
        ST_STREAM = 2'd2,  // popping words into the output register
        ST_DRAIN  = 2'd3   // final word popped, waiting for it to be accepted
    } state_t;

    localparam int DEF_WIDTH  = 32;  // data width and FIFO count width
    localparam int DEF_LEN_W  = 16;  // burst length width
    localparam int DEF_THRESH = 16;  // minimum fill (words) before a burst starts

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for the burst reader: captures a popped FIFO word and presents it downstream.
// Latency: one cycle from load to m_valid.
// Backpressure: word and last flag hold stable while m_valid=1 and m_ready=0; caller loads only when the slot frees.
//
// Ports: clk, reset (sync, active-high); load/load_data/load_last from the pop logic;
//        m_valid/m_data/m_last/m_ready form the downstream valid-ready handshake.
module stream_out_reg
    import fifo_burst_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            // A load only happens when the slot is empty or being emptied this cycle,
            // so overwriting here never loses a word.
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops req_len words from a FWFT FIFO once fill reaches min(len, THRESH) and streams them out.
// Latency: one cycle from fifo_re to m_valid; done pulses the cycle after the last word is accepted.
// Backpressure: pops stall when m_valid=1 and m_ready=0 or when the FIFO is empty; requests are refused while busy.
//
// Ports: clk, reset (sync, active-high); req_valid/req_len/req_ready burst request;
//        fifo_empty/fifo_count/fifo_dout/fifo_re FIFO read side; m_valid/m_data/m_last/m_ready output stream;
//        busy (burst in progress), done (one-cycle completion pulse).
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_count,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_re,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [WIDTH-1:0] rem_ext;
    logic [WIDTH-1:0] thr_ext;
    logic [WIDTH-1:0] start_lvl;
    logic             start_ok;
    logic             req_take;
    logic             last_pop;
    logic             last_acc;

    // Short bursts must not wait for a full THRESH of data that will never be read.
    assign rem_ext   = WIDTH'(remaining);
    assign thr_ext   = WIDTH'(THRESH);
    assign start_lvl = (rem_ext < thr_ext) ? rem_ext : thr_ext;
    assign start_ok  = (fifo_count >= start_lvl);

    // Zero-length requests are handshaken but never leave IDLE.
    assign req_take  = (state == ST_IDLE) && req_valid && (req_len != '0);
    assign last_pop  = fifo_re && (remaining == LEN_W'(1));
    assign last_acc  = m_valid && m_ready && m_last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (req_take) state_nxt = ST_WAIT;
            ST_WAIT:   if (start_ok) state_nxt = ST_STREAM;
            ST_STREAM: if (last_pop) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (last_acc) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. The pop is gated by reset so an abandoned burst cannot
    // consume one more FIFO word in the reset cycle itself.
    always_comb begin
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        fifo_re   = !reset && (state == ST_STREAM) && !fifo_empty &&
                    (remaining != '0) && (!m_valid || m_ready);
    end

    // Remaining-word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
        end else if (req_take) begin
            remaining <= req_len;
        end else if (fifo_re) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Completion pulse, registered so it lands the cycle after the final handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN) && last_acc;
        end
    end

    stream_out_reg #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (fifo_re),
        .load_data (fifo_dout),
        .load_last (last_pop),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width and FIFO count width.
REQ-002 SHALL have parameter LEN_W, default 16, meaning burst-length width.
REQ-003 SHALL have parameter THRESH, default 16, meaning minimum FIFO fill level (words) before a burst starts.
REQ-004 Ports, in this order:
 clk  in  1  sole clock; all state changes on its rising edge.
 reset  in  1  synchronous, active-high reset.
 req_valid  in  1  burst request strobe.
 req_len  in  LEN_W  burst length in words.
 req_ready  out  1  block can accept a request.
 fifo_empty  in  1  FIFO empty flag (registered, FWFT FIFO).
 fifo_count  in  WIDTH  FIFO occupancy (registered).
 fifo_dout  in  WIDTH  FIFO head word, valid while fifo_empty=0.
 fifo_re  out  1  FIFO pop strobe, one word per asserted cycle.
 m_valid  out  1  output word valid.
 m_data  out  WIDTH  output word.
 m_last  out  1  marks final word of the burst.
 m_ready  in  1  downstream accepts word.
 busy  out  1  burst in progress.
 done  out  1  one-cycle pulse after last word is accepted.

Function
REQ-005 SHALL implement states IDLE, WAIT, STREAM, DRAIN.
REQ-006 IDLE: req_ready=1; req_valid=1 with req_len!=0 SHALL latch remaining=req_len and go to WAIT; req_len=0 SHALL be accepted and ignored (stay IDLE, no done).
REQ-007 WAIT: SHALL go to STREAM when fifo_count >= min(remaining, THRESH), compared unsigned at WIDTH bits with remaining zero-extended.
REQ-008 STREAM: fifo_re SHALL equal (fifo_empty=0) AND (remaining!=0) AND (m_valid=0 OR m_ready=1), combinationally.
REQ-009 Each fifo_re cycle SHALL load fifo_dout into m_data, set m_valid=1 at the next edge, and decrement remaining by 1 (latency: one cycle from pop to m_valid).
REQ-010 m_last SHALL be loaded with 1 on the pop where remaining=1, else 0.
REQ-011 m_valid SHALL clear when m_ready=1 and no pop occurs in that cycle; m_data/m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-012 On the pop where remaining=1, the state SHALL move to DRAIN; no fifo_re in DRAIN.
REQ-013 DRAIN: on m_valid=1, m_ready=1, m_last=1 the block SHALL pulse done for one cycle and return to IDLE.
REQ-014 FIFO running empty mid-burst SHALL stall pops without leaving STREAM; m_valid drops after the held word is accepted.
REQ-015 Sustained throughput SHALL be one word per cycle when FIFO non-empty and m_ready=1.
REQ-016 busy SHALL be 1 in WAIT, STREAM, DRAIN; req_ready SHALL be 0 in those states; requests there SHALL be ignored.
REQ-017 fifo_re SHALL never be asserted when fifo_empty=1 or outside STREAM.

Reset
REQ-018 reset SHALL force state IDLE, remaining=0, m_valid=0, m_last=0, m_data=0, done=0, busy=0, fifo_re=0, req_ready=1 at the next edge, with priority over all other inputs.
REQ-019 Reset mid-burst SHALL abandon the burst: no further pops; words already popped are discarded; no done pulse.

Structure
REQ-020 State encoding and default parameter constants SHALL reside in a shared package fifo_burst_pkg.
REQ-021 The output register (m_valid/m_data/m_last hold and load logic) SHALL be a sub-module stream_out_reg; the FSM and remaining counter stay in the top module.

Verification
REQ-022 req_len=4, FIFO preloaded with 8 words 0xA0..0xA7, m_ready=1 -> fifo_re high 4 consecutive cycles, m_data 0xA0..0xA3 on consecutive cycles, m_last on 0xA3, done one cycle later, fifo_count ends 4.
REQ-023 req_len=32, THRESH=16, FIFO fill rises 1 word/cycle from 0 -> no fifo_re until fifo_count=16, then 32 words emitted in order with m_last on the 32nd.
REQ-024 req_len=3, m_ready toggling 1,0,0,1,... -> m_data held stable while m_ready=0, no word lost or duplicated, exactly 3 pops.
REQ-025 req_len=0 in IDLE -> no state change, no fifo_re, no done; a req_valid during STREAM -> ignored, burst length unchanged.
REQ-026 reset asserted after 2 of 6 words popped -> next cycle m_valid=0, fifo_re=0, req_ready=1, no done; later req_len=2 runs normally.
REQ-027 FIFO empties after 2 of 5 words -> STREAM held, m_valid drops, pops resume when fifo_empty=0, 5 words total with m_last on the 5th.
